// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan driver: frame-coherent snapshot, leading-zero
// suppression, per-digit decimal point, blanking and blinking, registered outputs.
module ssd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   code_bus,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_blank,
  output logic [7:0]                ssd,
  output logic [NUM_DIGITS-1:0]     digit_an,
  output logic                      frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]             cnt_r;
  logic [IW-1:0]             idx_r;
  logic [BW-1:0]             blink_cnt_r;
  logic                      phase_r;
  logic [4*NUM_DIGITS-1:0]   snap_code_r;
  logic [NUM_DIGITS-1:0]     snap_dp_r;
  logic [NUM_DIGITS-1:0]     snap_blank_r;
  logic [NUM_DIGITS-1:0]     snap_blink_r;
  logic                      snap_lz_r;
  logic [7:0]                ssd_r;
  logic [NUM_DIGITS-1:0]     an_r;
  logic                      tick_r;

  logic                      slot_end_s;
  logic                      wrap_s;
  logic                      load_s;
  logic [3:0]                cur_code_s;
  logic                      cur_dp_s;
  logic                      cur_blank_s;
  logic                      cur_blink_s;
  logic                      cur_lz_s;
  logic                      zero_run_s;
  logic                      dark_s;
  logic [7:0]                seg_s;
  logic [7:0]                next_ssd_s;
  logic [NUM_DIGITS-1:0]     an_s;

  // Active-low segment pattern {a..g,dp}; dp left off, applied later from the mask.
  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 8'b0000_0011;
      4'd1:    seg_decode = 8'b1001_1111;
      4'd2:    seg_decode = 8'b0010_0101;
      4'd3:    seg_decode = 8'b0000_1101;
      4'd4:    seg_decode = 8'b1001_1001;
      4'd5:    seg_decode = 8'b0100_1001;
      4'd6:    seg_decode = 8'b0100_0001;
      4'd7:    seg_decode = 8'b0001_1111;
      4'd8:    seg_decode = 8'b0000_0001;
      4'd9:    seg_decode = 8'b0000_1001;
      4'd10:   seg_decode = 8'b1110_0011;
      4'd11:   seg_decode = 8'b0110_0001;
      4'd12:   seg_decode = 8'b1000_0011;
      4'd13:   seg_decode = 8'b0001_0011;
      default: seg_decode = 8'b1111_1111;
    endcase
  endfunction

  assign slot_end_s = (cnt_r == CNT_LAST);
  assign wrap_s     = en && slot_end_s && (idx_r == IDX_LAST);
  assign load_s     = en && (cnt_r == {CW{1'b0}}) && (idx_r == {IW{1'b0}});

  // Select the active digit's snapshot fields; zero_run tracks "this and all higher digits are 0".
  always_comb begin
    cur_code_s  = 4'hF;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    cur_blink_s = 1'b0;
    cur_lz_s    = 1'b0;
    zero_run_s  = 1'b1;
    an_s        = {NUM_DIGITS{1'b1}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (snap_code_r[4*i +: 4] == 4'h0);
      if (idx_r == IW'(i)) begin
        cur_code_s  = snap_code_r[4*i +: 4];
        cur_dp_s    = snap_dp_r[i];
        cur_blank_s = snap_blank_r[i];
        cur_blink_s = snap_blink_r[i];
        cur_lz_s    = snap_lz_r && zero_run_s && (i != 0);
        an_s[i]     = 1'b0;
      end else begin
        an_s[i]     = 1'b1;
      end
    end
  end

  // Dark digits keep their enable slot but drive every segment, dp included, off.
  always_comb begin
    dark_s = cur_blank_s || (cur_blink_s && phase_r) || cur_lz_s;
    seg_s  = seg_decode(cur_code_s);
    if (dark_s) begin
      next_ssd_s = 8'hFF;
    end else begin
      next_ssd_s = {seg_s[7:1], ~cur_dp_s};
    end
  end

  // Refresh counter, digit index and blink frame counter / phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      idx_r       <= {IW{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b0;
    end else if (en) begin
      if (slot_end_s) begin
        cnt_r <= {CW{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + IW'(1);
        end
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (wrap_s) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= {BW{1'b0}};
          phase_r     <= ~phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BW'(1);
        end
      end
    end
  end

  // Frame-start snapshot of all display inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_code_r  <= {(4*NUM_DIGITS){1'b1}};
      snap_dp_r    <= {NUM_DIGITS{1'b0}};
      snap_blank_r <= {NUM_DIGITS{1'b0}};
      snap_blink_r <= {NUM_DIGITS{1'b0}};
      snap_lz_r    <= 1'b0;
    end else if (load_s) begin
      snap_code_r  <= code_bus;
      snap_dp_r    <= dp_mask;
      snap_blank_r <= blank_mask;
      snap_blink_r <= blink_mask;
      snap_lz_r    <= lz_blank;
    end
  end

  // Registered pin drivers; disabled scan forces the display fully dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      ssd_r  <= 8'hFF;
      an_r   <= {NUM_DIGITS{1'b1}};
      tick_r <= 1'b0;
    end else if (en) begin
      ssd_r  <= next_ssd_s;
      an_r   <= an_s;
      tick_r <= wrap_s;
    end else begin
      ssd_r  <= 8'hFF;
      an_r   <= {NUM_DIGITS{1'b1}};
      tick_r <= 1'b0;
    end
  end

  assign ssd        = ssd_r;
  assign digit_an   = an_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomized self-checking bench for ssd_scan_controller against a position-based
// reference model (enabled-cycle count -> digit, frame, blink phase, snapshot).
module tb_ssd_scan_controller;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FR = RD * ND;

  logic            clk;
  logic            rst;
  logic            en;
  logic [15:0]     code_bus;
  logic [3:0]      dp_mask;
  logic [3:0]      blank_mask;
  logic [3:0]      blink_mask;
  logic            lz_blank;
  logic [7:0]      ssd;
  logic [3:0]      digit_an;
  logic            frame_tick;

  int n_chk;
  int n_pass;

  logic [7:0]  seg_tbl [16];
  int          pos;
  logic [15:0] m_code;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  logic        m_lz;

  ssd_scan_controller #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .code_bus   (code_bus),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .ssd        (ssd),
    .digit_an   (digit_an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s pos=%0d got=%h exp=%h", tag, pos, got, exp);
    end
  endtask

  // One clock: predict outputs from the model, clock, compare, then advance the model.
  task automatic run_cycle();
    logic [7:0] e_ssd;
    logic [3:0] e_an;
    logic       e_ft;
    logic [3:0] c;
    logic       ph;
    logic       dark;
    int         d;
    int         frame;
    if (rst || !en) begin
      e_ssd = 8'hFF;
      e_an  = 4'b1111;
      e_ft  = 1'b0;
    end else begin
      d     = (pos / RD) % ND;
      frame = pos / FR;
      ph    = ((frame / BF) % 2) == 1;
      c     = m_code[4*d +: 4];
      dark  = m_blank[d] || (m_blink[d] && ph) ||
              (m_lz && (d > 0) && ((m_code >> (4*d)) == 16'h0000));
      e_ssd = dark ? 8'hFF : {seg_tbl[c][7:1], ~m_dp[d]};
      e_an  = ~(4'b0001 << d);
      e_ft  = ((pos % FR) == FR - 1);
    end
    @(posedge clk);
    #1;
    check_eq("ssd", {24'd0, ssd}, {24'd0, e_ssd});
    check_eq("digit_an", {28'd0, digit_an}, {28'd0, e_an});
    check_eq("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
    if (rst) begin
      pos     = 0;
      m_code  = 16'hFFFF;
      m_dp    = 4'b0000;
      m_blank = 4'b0000;
      m_blink = 4'b0000;
      m_lz    = 1'b0;
    end else if (en) begin
      if ((pos % FR) == 0) begin
        m_code  = code_bus;
        m_dp    = dp_mask;
        m_blank = blank_mask;
        m_blink = blink_mask;
        m_lz    = lz_blank;
      end
      pos++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] v;
    v = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    seg_tbl[0]  = 8'b0000_0011; seg_tbl[1]  = 8'b1001_1111;
    seg_tbl[2]  = 8'b0010_0101; seg_tbl[3]  = 8'b0000_1101;
    seg_tbl[4]  = 8'b1001_1001; seg_tbl[5]  = 8'b0100_1001;
    seg_tbl[6]  = 8'b0100_0001; seg_tbl[7]  = 8'b0001_1111;
    seg_tbl[8]  = 8'b0000_0001; seg_tbl[9]  = 8'b0000_1001;
    seg_tbl[10] = 8'b1110_0011; seg_tbl[11] = 8'b0110_0001;
    seg_tbl[12] = 8'b1000_0011; seg_tbl[13] = 8'b0001_0011;
    seg_tbl[14] = 8'b1111_1111; seg_tbl[15] = 8'b1111_1111;
    n_chk = 0;
    n_pass = 0;
    pos = 0;
    m_code = 16'hFFFF; m_dp = 4'b0000; m_blank = 4'b0000; m_blink = 4'b0000; m_lz = 1'b0;

    rst = 1'b1; en = 1'b1; code_bus = 16'h9876; dp_mask = 4'b1111;
    blank_mask = 4'b0000; blink_mask = 4'b0000; lz_blank = 1'b1;
    run(3);
    rst = 1'b0; code_bus = 16'h1234; dp_mask = 4'b0000; lz_blank = 1'b0;
    run(40);

    lz_blank = 1'b1; code_bus = 16'h0050; run(32);
    code_bus = 16'h0000; run(32);
    code_bus = 16'h0D0B; run(32);
    lz_blank = 1'b0;

    while ((pos % FR) != 0) run_cycle();
    code_bus = 16'h1234; run(9);
    code_bus = 16'h5678; run(30);

    dp_mask = 4'b0100; run(32);
    dp_mask = 4'b0000; blink_mask = 4'b0001; run(96);
    blink_mask = 4'b0000;

    while (((pos / RD) % ND) != 1) run_cycle();
    run(1);
    en = 1'b0; run(3);
    en = 1'b1; run(20);
    while (((pos / RD) % ND) != 3) run_cycle();
    rst = 1'b1; run(1);
    rst = 1'b0; run(40);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 15) == 0) code_bus = rand_code();
      if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lz_blank = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      run_cycle();
    end
    rst = 1'b0; en = 1'b1;
    run(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
